// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Single-outstanding instruction fetch unit with a one-entry
//               valid/ready instruction buffer, PC redirect and halt.
// Revision    : 1.0 - initial release
// ============================================================================

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        redirect_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_instr_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic        r_misaligned;
  logic        w_consume;

  assign w_consume = r_instr_valid && instr_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_valid_nxt    = r_instr_valid && !w_consume;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;

    case (r_state)
      S_IDLE: begin
        if (!halt && (!r_instr_valid || w_consume)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_IDLE;
          if (r_drop) begin
            w_drop_nxt = 1'b0;
          end else if (!redirect_valid) begin
            w_instr_nxt    = imem_rdata;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + 32'd4;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A redirect overrides everything; a request already in flight is
    // marked for discard so its response never reaches the buffer.
    if (redirect_valid) begin
      w_pc_nxt    = {redirect_pc[31:2], 2'b00};
      w_valid_nxt = 1'b0;
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_REQ:   w_drop_nxt  = 1'b1;
        S_WAIT:  w_drop_nxt  = !imem_rvalid;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_drop        <= w_drop_nxt;
      r_instr_valid <= w_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_misaligned  <= redirect_valid && (|redirect_pc[1:0]);
    end
  end

  assign imem_req            = (r_state == S_REQ);
  assign imem_addr           = (r_state == S_REQ) ? r_pc : 32'd0;
  assign instr_valid         = r_instr_valid;
  assign instr               = r_instr;
  assign instr_pc            = r_instr_pc;
  assign redirect_misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed scenarios plus a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        redirect_misaligned;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit rand_lat = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  ev_t req_q[$];
  ev_t out_q[$];

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .instr_valid         (instr_valid),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .instr_ready         (instr_ready),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .halt                (halt),
    .redirect_misaligned (redirect_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Instruction memory: answers each request after lat cycles with memf(addr).
  initial begin : mem_model
    logic [31:0] a;
    int          l;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        a = imem_addr;
        l = rand_lat ? int'($urandom_range(1, 4)) : lat;
        repeat (l) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = memf(a);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
  end

  // Event log of requests and consumed instructions, sampled mid-cycle.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (imem_req === 1'b1) begin
          e.a = imem_addr; e.d = 32'd0; e.c = cyc;
          req_q.push_back(e);
        end
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
          e.a = instr_pc; e.d = instr; e.c = cyc;
          out_q.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (8) tick();
    req_q.delete();
    out_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (req_q.size() >= k);
    end
  endtask

  task automatic wait_out(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (out_q.size() >= k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++; if (instr_pc !== 32'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (redirect_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", redirect_misaligned); end
  endtask

  task automatic test_stream();
    bit ok;
    lat = 1; instr_ready = 1'b1; halt = 1'b0;
    apply_reset();
    wait_req(3, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_req_timeout: got %0d reqs want 3", req_q.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (req_q[i].a !== RESET_PC + 32'(4 * i)) begin
          n_fail++; $display("FAIL stream_addr%0d: got %h want %h", i, req_q[i].a, RESET_PC + 32'(4 * i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (req_q[i].c - req_q[i-1].c != 3) begin
          n_fail++; $display("FAIL stream_gap%0d: got %0d cycles want 3", i, req_q[i].c - req_q[i-1].c);
        end
      end
    end
    wait_out(3, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_out_timeout: got %0d instrs want 3", out_q.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_q[i].a !== 32'(4 * i) || out_q[i].d !== memf(32'(4 * i))) begin
          n_fail++; $display("FAIL stream_instr%0d: got pc %h instr %h want pc %h instr %h",
                             i, out_q[i].a, out_q[i].d, 32'(4 * i), memf(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] hold_i, hold_pc;
    lat = 1; instr_ready = 1'b0; halt = 1'b0;
    apply_reset();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = (instr_valid === 1'b1); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_fill_timeout: got valid %b want 1", instr_valid); end
    n_checks++;
    if (instr_pc !== 32'd0 || instr !== memf(32'd0)) begin
      n_fail++; $display("FAIL stall_first: got pc %h instr %h want pc 0 instr %h", instr_pc, instr, memf(32'd0));
    end
    hold_i = instr; hold_pc = instr_pc;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== hold_i || instr_pc !== hold_pc || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got v %b pc %h instr %h req %b want v 1 pc %h instr %h req 0",
                           i, instr_valid, instr_pc, instr, imem_req, hold_pc, hold_i);
      end
    end
    instr_ready = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL stall_resume: got req %b addr %h want req 1 addr 4", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    lat = 4; instr_ready = 1'b1; halt = 1'b0;
    apply_reset();
    wait_req(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rw_req0_timeout: got %0d reqs want 1", req_q.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_req(2, 30, ok);
    n_checks++; if (!ok || req_q[1].a !== 32'h100) begin
      n_fail++; $display("FAIL rw_next_addr: got %h want 100", ok ? req_q[1].a : 32'hx);
    end
    wait_out(1, 30, ok);
    n_checks++; if (!ok || out_q[0].a !== 32'h100 || out_q[0].d !== memf(32'h100)) begin
      n_fail++; $display("FAIL rw_first_instr: got pc %h instr %h want pc 100 instr %h",
                         ok ? out_q[0].a : 32'hx, ok ? out_q[0].d : 32'hx, memf(32'h100));
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    lat = 1; instr_ready = 1'b1; halt = 1'b1;
    apply_reset();
    repeat (4) tick();
    n_checks++; if (req_q.size() != 0) begin n_fail++; $display("FAIL mis_halt_idle: got %0d reqs want 0", req_q.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (redirect_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", redirect_misaligned); end
    tick();
    n_checks++; if (redirect_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", redirect_misaligned); end
    halt = 1'b0;
    wait_req(1, 20, ok);
    n_checks++; if (!ok || req_q[0].a !== 32'h100) begin
      n_fail++; $display("FAIL mis_next_addr: got %h want 100", ok ? req_q[0].a : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    int s;
    lat = 2; instr_ready = 1'b1; halt = 1'b0;
    apply_reset();
    wait_req(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL col_req0_timeout: got %0d reqs want 1", req_q.size()); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    wait_req(2, 30, ok);
    n_checks++; if (!ok || req_q[1].a !== 32'h200) begin
      n_fail++; $display("FAIL col_next_addr: got %h want 200", ok ? req_q[1].a : 32'hx);
    end
    wait_out(1, 30, ok);
    n_checks++; if (!ok || out_q[0].a !== 32'h200) begin
      n_fail++; $display("FAIL col_first_pc: got %h want 200", ok ? out_q[0].a : 32'hx);
    end
    // Full buffer discarded by a redirect while the decoder is stalled.
    instr_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = (instr_valid === 1'b1); end
    n_checks++; if (!ok || instr_pc !== 32'h204) begin
      n_fail++; $display("FAIL col_buf_pc: got v %b pc %h want v 1 pc 204", instr_valid, instr_pc);
    end
    s = out_q.size();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL col_buf_clear: got %b want 0", instr_valid); end
    instr_ready = 1'b1;
    wait_out(s + 1, 30, ok);
    n_checks++; if (!ok || out_q[s].a !== 32'h300) begin
      n_fail++; $display("FAIL col_after_clear: got pc %h want 300", ok ? out_q[s].a : 32'hx);
    end
  endtask

  task automatic test_halt();
    bit ok;
    lat = 3; instr_ready = 1'b1; halt = 1'b0;
    apply_reset();
    wait_req(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL halt_req0_timeout: got %0d reqs want 1", req_q.size()); end
    halt = 1'b1;
    wait_out(1, 20, ok);
    n_checks++; if (!ok || out_q[0].a !== 32'h0) begin
      n_fail++; $display("FAIL halt_fill: got pc %h want 0", ok ? out_q[0].a : 32'hx);
    end
    repeat (10) tick();
    n_checks++; if (req_q.size() != 1) begin n_fail++; $display("FAIL halt_block: got %0d reqs want 1", req_q.size()); end
    halt = 1'b0;
    wait_req(2, 20, ok);
    n_checks++; if (!ok || req_q[1].a !== 32'h4) begin
      n_fail++; $display("FAIL halt_resume: got %h want 4", ok ? req_q[1].a : 32'hx);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    lat = 4; instr_ready = 1'b1; halt = 1'b0;
    apply_reset();
    wait_out(2, 40, ok);
    wait_req(3, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ar_req_timeout: got %0d reqs want 3", req_q.size()); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr_valid !== 1'b0 ||
        instr !== 32'd0 || instr_pc !== 32'd0 || redirect_misaligned !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate: got req %b addr %h v %b instr %h pc %h mis %b want all 0",
                         imem_req, imem_addr, instr_valid, instr, instr_pc, redirect_misaligned);
    end
    repeat (8) tick();
    req_q.delete();
    out_q.delete();
    rst = 1'b0;
    wait_req(1, 20, ok);
    n_checks++; if (!ok || req_q[0].a !== RESET_PC) begin
      n_fail++; $display("FAIL ar_first_addr: got %h want %h", ok ? req_q[0].a : 32'hx, RESET_PC);
    end
    wait_out(1, 20, ok);
    n_checks++; if (!ok || out_q[0].a !== RESET_PC || out_q[0].d !== memf(RESET_PC)) begin
      n_fail++; $display("FAIL ar_first_instr: got pc %h instr %h want pc %h instr %h",
                         ok ? out_q[0].a : 32'hx, ok ? out_q[0].d : 32'hx, RESET_PC, memf(RESET_PC));
    end
  endtask

  // Transaction model: one fetch in flight, killed by any redirect seen while
  // it is in flight; a surviving response fills the one-entry buffer.
  task automatic test_random();
    logic        rq, v0, st_out;
    logic [31:0] ad;
    logic        m_valid, m_mis, m_out, m_killed, m_allow;
    logic [31:0] m_pc, m_instr, m_fetch, m_oaddr;
    halt = 1'b1; instr_ready = 1'b1; rand_lat = 1'b1;
    apply_reset();
    m_valid = 1'b0; m_mis = 1'b0; m_out = 1'b0; m_killed = 1'b0; m_allow = 1'b0;
    m_pc = 32'd0; m_instr = 32'd0; m_fetch = RESET_PC; m_oaddr = 32'd0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      instr_ready    = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = 32'hFFFF_FFFC;
        1:       redirect_pc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        default: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
      #2;
      rq = imem_req;
      ad = imem_addr;
      n_checks++; if (rq !== m_allow) begin n_fail++; $display("FAIL rnd_req t=%0d: got %b want %b", t, rq, m_allow); end
      if (rq === 1'b1) begin
        n_checks++; if (ad !== m_fetch) begin n_fail++; $display("FAIL rnd_addr t=%0d: got %h want %h", t, ad, m_fetch); end
      end
      n_checks++; if (instr_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid t=%0d: got %b want %b", t, instr_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if (instr_pc !== m_pc || instr !== m_instr) begin
          n_fail++; $display("FAIL rnd_instr t=%0d: got pc %h instr %h want pc %h instr %h", t, instr_pc, instr, m_pc, m_instr);
        end
      end
      n_checks++; if (redirect_misaligned !== m_mis) begin n_fail++; $display("FAIL rnd_mis t=%0d: got %b want %b", t, redirect_misaligned, m_mis); end

      v0     = m_valid;
      st_out = m_out;
      if (m_valid && instr_ready) m_valid = 1'b0;
      if (rq === 1'b1) begin
        m_out = 1'b1; m_killed = 1'b0; m_oaddr = m_fetch;
      end
      if (m_out && redirect_valid) m_killed = 1'b1;
      if (st_out && imem_rvalid) begin
        if (!m_killed) begin
          m_valid = 1'b1; m_pc = m_oaddr; m_instr = memf(m_oaddr); m_fetch = m_oaddr + 32'd4;
        end
        m_out = 1'b0;
      end
      if (redirect_valid) begin
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_valid = 1'b0;
      end
      m_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
      m_allow = !rq && !st_out && !halt && !redirect_valid && (!v0 || instr_ready);
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;
    rand_lat       = 1'b0;
  endtask

  initial begin : main
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_misaligned();
    test_redirect_collide();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
